// File: rtl/audio_upsampler_pkg.sv
// audio_upsampler_pkg: shared widths, FSM encoding and burst-length helper for the upsampler
package audio_upsampler_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int CH_WIDTH = 16;
  localparam int ACC_WIDTH = CH_WIDTH + 4;
  typedef enum logic [2:0] {IDLE, RD, WAIT, LOAD, WR} state_t;
  function automatic logic [2:0] last_idx(input logic [1:0] s);
    return 3'((4'd1 << s) - 4'd1);
  endfunction
endpackage

// File: rtl/audio_upsampler_if.sv
// audio_upsampler_if: ADC FIFO read side and DAC FIFO write side; master = upsampler, slave = FIFOs
interface audio_upsampler_if;
  logic adcfifo_empty;
  logic adcfifo_read;
  logic [audio_upsampler_pkg::DATA_WIDTH-1:0] adcfifo_readdata;
  logic dacfifo_full;
  logic dacfifo_write;
  logic [audio_upsampler_pkg::DATA_WIDTH-1:0] dacfifo_writedata;
  modport master (
    input  adcfifo_empty, adcfifo_readdata, dacfifo_full,
    output adcfifo_read, dacfifo_write, dacfifo_writedata
  );
  modport slave (
    output adcfifo_empty, adcfifo_readdata, dacfifo_full,
    input  adcfifo_read, dacfifo_write, dacfifo_writedata
  );
endinterface

// File: rtl/upsample_lerp_ch.sv
// upsample_lerp_ch: one channel; load latches cur/diff/acc, step advances acc, commit moves cur to prev, dout = hold or acc>>>s
module upsample_lerp_ch
  import audio_upsampler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  input  logic commit,
  input  logic [1:0] s_load,
  input  logic [1:0] s,
  input  logic interp,
  input  logic signed [CH_WIDTH-1:0] din,
  output logic signed [CH_WIDTH-1:0] dout
);
  logic signed [CH_WIDTH-1:0] prev, cur;
  logic signed [CH_WIDTH:0] diff, diff_n;
  logic signed [ACC_WIDTH-1:0] acc;
  assign diff_n = {din[CH_WIDTH-1], din} - {prev[CH_WIDTH-1], prev};
  assign dout = interp ? CH_WIDTH'(acc >>> s) : cur;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      cur <= '0;
      diff <= '0;
      acc <= '0;
    end else begin
      if (load) begin
        cur <= din;
        diff <= diff_n;
        acc <= (ACC_WIDTH'(prev) <<< s_load) + ACC_WIDTH'(diff_n);
      end else if (step) acc <= acc + ACC_WIDTH'(diff);
      if (commit) prev <= cur;
    end
  end
endmodule

// File: rtl/audio_upsampler.sv
// audio_upsampler: reads one ADC stereo word, writes 2^shift DAC words (hold or lerp); ports clk, reset, shift, interp_en, busy, fifo handshake
module audio_upsampler
  import audio_upsampler_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic [1:0] shift,
  input  logic interp_en,
  output logic busy,
  audio_upsampler_if.master fifo
);
  state_t state;
  logic [2:0] j;
  logic [1:0] s_q;
  logic mode, load, wr_ok, last;
  logic [CH_WIDTH-1:0] word_a, word_b;
  always_comb begin
    load = state == LOAD;
    wr_ok = state == WR && !fifo.dacfifo_full;
    last = wr_ok && j == last_idx(s_q);
  end
  assign busy = state != IDLE;
  assign fifo.adcfifo_read = state == RD;
  assign fifo.dacfifo_write = wr_ok;
  assign fifo.dacfifo_writedata = {word_a, word_b};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      j <= '0;
      s_q <= '0;
      mode <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!fifo.adcfifo_empty) state <= RD;
        RD: state <= WAIT;
        WAIT: state <= LOAD;
        LOAD: begin
          state <= WR;
          j <= '0;
          s_q <= shift;
          mode <= interp_en;
        end
        WR: if (wr_ok) begin
          j <= j + 3'd1;
          if (last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  upsample_lerp_ch u_a (
    .clk(clk), .rst(reset), .load(load), .step(wr_ok), .commit(last),
    .s_load(shift), .s(s_q), .interp(mode),
    .din(fifo.adcfifo_readdata[DATA_WIDTH-1:CH_WIDTH]), .dout(word_a)
  );
  upsample_lerp_ch u_b (
    .clk(clk), .rst(reset), .load(load), .step(wr_ok), .commit(last),
    .s_load(shift), .s(s_q), .interp(mode),
    .din(fifo.adcfifo_readdata[CH_WIDTH-1:0]), .dout(word_b)
  );
endmodule

// File: tb/tb_audio_upsampler.sv
// tb_audio_upsampler: randomized self-checking bench against an arithmetic upsampling model
module tb_audio_upsampler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] shift = 2'd0;
  logic interp_en = 1'b0;
  logic busy;
  audio_upsampler_if bus();
  audio_upsampler dut (
    .clk(clk), .reset(reset), .shift(shift), .interp_en(interp_en),
    .busy(busy), .fifo(bus)
  );
  always #5 clk = ~clk;
  logic [31:0] adc_mem [256];
  int pushed = 0, rd_ptr = 0, bad_read = 0, cyc = 0, wr_full = 0;
  logic [31:0] dac_q[$];
  int dac_t[$];
  logic [31:0] exp_q[$];
  int prev_a = 0, prev_b = 0;
  int n_tests = 0, n_fail = 0;
  assign bus.adcfifo_empty = rd_ptr >= pushed;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.adcfifo_read) begin
      if (rd_ptr < pushed) begin
        bus.adcfifo_readdata <= adc_mem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end else bad_read <= bad_read + 1;
    end
  end
  always @(negedge clk) begin
    if (bus.dacfifo_write) begin
      dac_q.push_back(bus.dacfifo_writedata);
      dac_t.push_back(cyc);
      if (bus.dacfifo_full) wr_full <= wr_full + 1;
    end
  end
  function automatic int fdiv(input int v, input int n);
    int q;
    q = v / n;
    if (v % n != 0 && v < 0) q = q - 1;
    return q;
  endfunction
  task automatic model(input logic [31:0] w, input logic [1:0] s, input logic ie);
    int n, ca, cb, a, b;
    n = 1 << s;
    ca = int'($signed(w[31:16]));
    cb = int'($signed(w[15:0]));
    exp_q.delete();
    for (int i = 1; i <= n; i++) begin
      a = ie ? prev_a + fdiv((ca - prev_a) * i, n) : ca;
      b = ie ? prev_b + fdiv((cb - prev_b) * i, n) : cb;
      exp_q.push_back({a[15:0], b[15:0]});
    end
    prev_a = ca;
    prev_b = cb;
  endtask
  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    prev_a = 0;
    prev_b = 0;
  endtask
  task automatic do_sample(input logic [31:0] w, input logic [1:0] s, input logic ie,
                           input int full_mode, input logic [1:0] s_mid, input string name,
                           output int start);
    int t0, k, cnt;
    bit saw;
    model(w, s, ie);
    shift = s;
    interp_en = ie;
    start = dac_q.size();
    adc_mem[pushed] = w;
    pushed = pushed + 1;
    t0 = cyc;
    saw = 0;
    for (k = 0; k < 300; k++) begin
      @(posedge clk); #2;
      if (busy) saw = 1;
      else if (saw) break;
      if (dac_q.size() > start) shift = s_mid;
      if (full_mode == 1) bus.dacfifo_full = ~bus.dacfifo_full;
      else if (full_mode == 2) bus.dacfifo_full = 1'($urandom_range(0, 1));
    end
    bus.dacfifo_full = 1'b0;
    n_tests++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL %s timeout: busy never completed within %0d cycles (required < 300)", name, k);
    end
    cnt = dac_q.size() - start;
    n_tests++;
    if (cnt !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d writes, expected %0d", name, cnt, exp_q.size());
    end
    for (int i = 0; i < cnt && i < exp_q.size(); i++) begin
      n_tests++;
      if (dac_q[start + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s word%0d: got %h expected %h", name, i, dac_q[start + i], exp_q[i]);
      end
    end
    if (cnt > 0) begin
      n_tests++;
      if (dac_t[start] - t0 < 4) begin
        n_fail++;
        $display("FAIL %s latency: first write after %0d cycles, expected >= 4", name, dac_t[start] - t0);
      end
    end
  endtask
  task automatic test_reset();
    n_tests += 4;
    if (bus.adcfifo_read !== 1'b0) begin n_fail++; $display("FAIL reset read: got %b expected 0", bus.adcfifo_read); end
    if (bus.dacfifo_write !== 1'b0) begin n_fail++; $display("FAIL reset write: got %b expected 0", bus.dacfifo_write); end
    if (bus.dacfifo_writedata !== 32'h0) begin n_fail++; $display("FAIL reset data: got %h expected 0", bus.dacfifo_writedata); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
  endtask
  task automatic test_single();
    int st;
    do_sample(32'h1234_ABCD, 2'd0, 1'b1, 0, 2'd0, "single", st);
    do_sample(32'h1234_ABCD, 2'd1, 1'b1, 0, 2'd1, "single_prev", st);
  endtask
  task automatic test_hold();
    int st;
    do_sample(32'h0100_FF00, 2'd2, 1'b0, 0, 2'd2, "hold", st);
    for (int i = 0; i < 4 && st + i < dac_q.size(); i++) begin
      n_tests++;
      if (dac_q[st + i] !== 32'h0100_FF00) begin
        n_fail++;
        $display("FAIL hold_const word%0d: got %h expected 0100ff00", i, dac_q[st + i]);
      end
    end
  endtask
  task automatic test_interp();
    int st;
    logic [31:0] want [4];
    want[0] = 32'h0040_FFC0;
    want[1] = 32'h0080_FF80;
    want[2] = 32'h00C0_FF40;
    want[3] = 32'h0100_FF00;
    do_reset();
    do_sample(32'h0100_FF00, 2'd2, 1'b1, 0, 2'd2, "interp", st);
    for (int i = 0; i < 4 && st + i < dac_q.size(); i++) begin
      n_tests++;
      if (dac_q[st + i] !== want[i]) begin
        n_fail++;
        $display("FAIL interp_const word%0d: got %h expected %h", i, dac_q[st + i], want[i]);
      end
    end
  endtask
  task automatic test_stall();
    int st;
    do_sample({16'($urandom), 16'($urandom)}, 2'd3, 1'b1, 1, 2'd3, "stall", st);
    n_tests++;
    if (wr_full !== 0) begin
      n_fail++;
      $display("FAIL stall write_while_full: got %0d expected 0", wr_full);
    end
  endtask
  task automatic test_reset_mid();
    int st, k;
    do_reset();
    model(32'h0200_FE00, 2'd2, 1'b1);
    shift = 2'd2;
    interp_en = 1'b1;
    st = dac_q.size();
    adc_mem[pushed] = 32'h0200_FE00;
    pushed = pushed + 1;
    for (k = 0; k < 300; k++) begin
      @(posedge clk); #2;
      if (dac_q.size() - st >= 2) break;
    end
    n_tests++;
    if (k >= 300) begin n_fail++; $display("FAIL reset_mid timeout: %0d cycles", k); end
    for (int i = 0; i < 2 && st + i < dac_q.size(); i++) begin
      n_tests++;
      if (dac_q[st + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_mid word%0d: got %h expected %h", i, dac_q[st + i], exp_q[i]);
      end
    end
    reset = 1'b1;
    @(posedge clk); #2;
    test_reset();
    reset = 1'b0;
    prev_a = 0;
    prev_b = 0;
    do_sample(32'h0100_0000, 2'd2, 1'b1, 0, 2'd2, "after_reset", st);
    n_tests++;
    if (st < dac_q.size() && dac_q[st] !== 32'h0040_0000) begin
      n_fail++;
      $display("FAIL after_reset first: got %h expected 00400000", dac_q[st]);
    end
  endtask
  task automatic test_shift_change();
    int st;
    do_sample({16'($urandom), 16'($urandom)}, 2'd1, 1'b1, 0, 2'd3, "shift_mid", st);
    do_sample({16'($urandom), 16'($urandom)}, 2'd3, 1'b1, 0, 2'd3, "shift_next", st);
  endtask
  task automatic test_random();
    int st;
    for (int i = 0; i < 12; i++)
      do_sample({16'($urandom), 16'($urandom)}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                2 * int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), "random", st);
    n_tests++;
    if (wr_full !== 0) begin
      n_fail++;
      $display("FAIL random write_while_full: got %0d expected 0", wr_full);
    end
  endtask
  task automatic test_idle();
    bit seen;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #2;
      if (busy || bus.adcfifo_read) seen = 1;
    end
    n_tests += 2;
    if (seen) begin n_fail++; $display("FAIL idle activity: got busy/read while empty, expected none"); end
    if (bad_read !== 0) begin n_fail++; $display("FAIL idle bad_read: got %0d reads from empty FIFO, expected 0", bad_read); end
  endtask
  initial begin
    bus.dacfifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    test_reset();
    reset = 1'b0;
    test_single();
    test_hold();
    test_interp();
    test_stall();
    test_reset_mid();
    test_shift_change();
    test_random();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
